// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator: valid/ready request in, one bus cycle, valid/ready response out.
// Optional bus timeout abort is built when WBM_TIMEOUT_EN is defined.
module wb_host_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_adr_i,
  input  logic [DATA_WIDTH-1:0] req_dat_i,
  input  logic [SEL_WIDTH-1:0]  req_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  output logic [SEL_WIDTH-1:0]  wbm_sel_o,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;

`ifdef WBM_TIMEOUT_EN
  localparam int            CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_ONE = CNT_W'(1);
  logic [CNT_W-1:0] tmo_q, tmo_d;
`endif

  // Next-state and output-register decode
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
`ifdef WBM_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d        = req_we_i;
          adr_d       = req_adr_i;
          dat_d       = req_dat_i;
          sel_d       = req_sel_i;
          cyc_d       = 1'b1;
          req_ready_d = 1'b0;
          state_d     = ST_BUS;
`ifdef WBM_TIMEOUT_EN
          tmo_d       = {CNT_W{1'b0}};
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        // err wins over a simultaneous ack
        if (wbm_err_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = {DATA_WIDTH{1'b0}};
          state_d     = ST_RESP;
        end else if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? {DATA_WIDTH{1'b0}} : wbm_dat_i;
          state_d     = ST_RESP;
        end else begin
`ifdef WBM_TIMEOUT_EN
          if (tmo_q == TMO_MAX) begin
            cyc_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_dat_d   = {DATA_WIDTH{1'b0}};
            state_d     = ST_RESP;
          end else begin
            tmo_d = tmo_q + TMO_ONE;
          end
`else
          state_d = ST_BUS;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        cyc_d       = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the bus cycle immediately
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= {DATA_WIDTH{1'b0}};
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= {ADDR_WIDTH{1'b0}};
      dat_q       <= {DATA_WIDTH{1'b0}};
      sel_q       <= {SEL_WIDTH{1'b0}};
`ifdef WBM_TIMEOUT_EN
      tmo_q       <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
`ifdef WBM_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed, table-driven bench for wb_host_master plus hand-written corner sequences.
module tb_wb_host_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_adr = 32'd0, req_dat = 32'd0;
  logic [3:0]  req_sel = 4'd0;
  logic        rsp_ready = 1'b0;
  logic        ack = 1'b0, err = 1'b0;
  logic [31:0] slv_dat = 32'd0;
  logic        req_ready, rsp_valid, rsp_err, cyc, stb, we;
  logic [31:0] rsp_dat, adr, wdat;
  logic [3:0]  sel;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;
    logic        ack;
    logic        err;
    logic [31:0] slv;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[6];

  wb_host_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_dat_i(req_dat), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
    .wbm_dat_o(wdat), .wbm_sel_o(sel), .wbm_dat_i(slv_dat),
    .wbm_ack_i(ack), .wbm_err_i(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) tick();
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  // Issue request and return after the accept edge with bus signals checked
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wait_ready();
    req_valid = 1'b1; req_we = w; req_adr = a; req_dat = d; req_sel = s;
    tick();
    req_valid = 1'b0; req_adr = ~a; req_dat = ~d; req_sel = ~s; req_we = ~w;
    chk("acc_ready_low", {31'd0, req_ready}, 32'd0);
    chk("acc_cyc", {30'd0, cyc, stb}, 32'd3);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    issue(v.we, v.adr, v.dat, v.sel);
    for (int c = 0; c <= v.waits; c++) begin
      chk({tag, "_bus_cyc"}, {30'd0, cyc, stb}, 32'd3);
      chk({tag, "_bus_adr"}, adr, v.adr);
      chk({tag, "_bus_dat"}, wdat, v.dat);
      chk({tag, "_bus_selwe"}, {27'd0, sel, we}, {27'd0, v.sel, v.we});
      chk({tag, "_bus_novalid"}, {31'd0, rsp_valid}, 32'd0);
      if (c == v.waits) begin
        ack = v.ack; err = v.err; slv_dat = v.slv;
      end else begin
        ack = 1'b0; err = 1'b0; slv_dat = 32'h0BAD_0BAD;
      end
      tick();
    end
    ack = 1'b0; err = 1'b0; slv_dat = 32'h0;
    chk({tag, "_end_cyc"}, {30'd0, cyc, stb}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
    chk({tag, "_rsp_dat"}, rsp_dat, v.exp_dat);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_hs_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_hs_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_keep_adr"}, adr, v.adr);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h3000_0010, 32'h1234_5678, 4'b0011, 3, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 1'b1, 1'b1, 32'hAAAA_5555, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h3000_0024, 32'h0, 4'h1, 2, 1'b0, 1'b1, 32'h5555_AAAA, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 32'h3000_0028, 32'hCAFE_F00D, 4'hC, 1, 1'b0, 1'b1, 32'h1111_2222, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 32'h3000_002C, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'h0000_00FF, 1'b0, 32'h0000_00FF};

    // Reset values while reset is held
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_flags", {27'd0, rsp_valid, rsp_err, cyc, stb, we}, 32'd0);
    chk("rst_dat", rsp_dat | adr | wdat, 32'd0);
    chk("rst_sel", {28'd0, sel}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Stray ack/err in IDLE are ignored
    ack = 1'b1; err = 1'b1;
    tick(); tick();
    ack = 1'b0; err = 1'b0;
    chk("idle_stray_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_stray_cyc", {31'd0, cyc}, 32'd0);
    chk("idle_stray_ready", {31'd0, req_ready}, 32'd1);

    // Response back-pressure with a pending second request
    issue(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    ack = 1'b1; slv_dat = 32'h8765_4321;
    tick();
    ack = 1'b0; slv_dat = 32'h0;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h3000_0044; req_dat = 32'h0F0F_0F0F; req_sel = 4'h6;
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_dat", rsp_dat, 32'h8765_4321);
      chk("bp_cyc", {31'd0, cyc}, 32'd0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_hs_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_hs_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_hs_cyc", {31'd0, cyc}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("bp_2nd_cyc", {31'd0, cyc}, 32'd1);
    chk("bp_2nd_adr", adr, 32'h3000_0044);
    chk("bp_2nd_dat", wdat, 32'h0F0F_0F0F);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("bp_2nd_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
    chk("bp_2nd_rdat", rsp_dat, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

`ifdef WBM_TIMEOUT_EN
    begin
      int n;
      issue(1'b0, 32'h3000_0080, 32'h0, 4'hF);
      n = 0;
      while (cyc === 1'b1 && n < 30) begin
        n++;
        tick();
      end
      chk("tmo_cyc_cycles", n, 32'd9);
      chk("tmo_rsp", {30'd0, rsp_valid, rsp_err}, 32'd3);
      chk("tmo_dat", rsp_dat, 32'd0);
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      issue(1'b0, 32'h3000_0084, 32'h0, 4'hF);
      for (int c = 0; c < 8; c++) tick();
      chk("tmo_late_cyc", {31'd0, cyc}, 32'd1);
      ack = 1'b1; slv_dat = 32'h0000_1234;
      tick();
      ack = 1'b0;
      chk("tmo_ack_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
      chk("tmo_ack_dat", rsp_dat, 32'h0000_1234);
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    end
`endif

    // Asynchronous reset during BUS
    issue(1'b0, 32'h3000_00C0, 32'h0, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", {30'd0, cyc, stb}, 32'd0);
    chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    chk("arst_post_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_post_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_post_cyc", {31'd0, cyc}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
